// File: rtl/rice_carry_tracker.sv
// Bit-window tracker for a Rice/Golomb decoder: consumes codeword lengths
// against a single buffered stream word and raises a carry when a code spans words.
module rice_carry_tracker #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned LEN_W  = $clog2(WORD_W) + 1,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             word_valid,
   output logic             word_ready,
   input  logic             len_valid,
   input  logic [LEN_W-1:0] len,
   output logic             len_ready,
   input  logic             flush,
   output logic             cout,
   output logic [LEN_W-1:0] remlen,
   output logic [LEN_W-2:0] offset,
   output logic [CNT_W-1:0] words,
   output logic [1:0]       state,
   output logic             err
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StWait = 2'd2
   } state_e;

   localparam logic [LEN_W-1:0] WordLen = LEN_W'(WORD_W);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] remlen_q, remlen_d;
   logic [LEN_W-2:0] offset_q, offset_d;
   logic [CNT_W-1:0] words_q;
   logic             cout_q, cout_d;
   logic             err_q, err_d;
   logic             word_ready_c, len_ready_c;
   logic             len_legal, len_fits;

   assign len_legal = (len != '0) && (len <= WordLen);
   assign len_fits  = (len <= remlen_q);

   always_comb begin
      state_d      = state_q;
      remlen_d     = remlen_q;
      cout_d       = 1'b0;
      err_d        = err_q;
      word_ready_c = 1'b0;
      len_ready_c  = 1'b0;
      if (flush) begin
         state_d  = StIdle;
         remlen_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               word_ready_c = 1'b1;
               if (word_valid) begin
                  remlen_d = WordLen;
                  state_d  = StRun;
               end
            end
            StRun, StWait: begin
               if (!len_valid) begin
                  state_d = StRun;
               end else if (!len_legal) begin
                  // Illegal lengths are dropped so the stream cannot stall on them.
                  len_ready_c = 1'b1;
                  err_d       = 1'b1;
                  state_d     = StRun;
               end else if (len_fits) begin
                  len_ready_c = 1'b1;
                  remlen_d    = remlen_q - len;
                  state_d     = (remlen_d == '0) ? StIdle : StRun;
               end else if (word_valid) begin
                  // Spanning code: tail of this word plus head of the next one.
                  word_ready_c = 1'b1;
                  len_ready_c  = 1'b1;
                  remlen_d     = remlen_q + (WordLen - len);
                  cout_d       = 1'b1;
                  state_d      = StRun;
               end else begin
                  state_d = StWait;
               end
            end
            default: begin
               state_d  = StIdle;
               remlen_d = '0;
            end
         endcase
      end
      offset_d = (LEN_W-1)'(WordLen - remlen_d);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         remlen_q <= '0;
         offset_q <= '0;
         words_q  <= '0;
         cout_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         remlen_q <= remlen_d;
         offset_q <= offset_d;
         cout_q   <= cout_d;
         err_q    <= err_d;
         if (word_ready_c && word_valid) begin
            words_q <= words_q + CNT_W'(1);
         end
      end
   end

   assign word_ready = reset & word_ready_c;
   assign len_ready  = reset & len_ready_c;
   assign cout       = cout_q;
   assign remlen     = remlen_q;
   assign offset     = offset_q;
   assign words      = words_q;
   assign state      = state_q;
   assign err        = err_q;

endmodule

// File: tb/tb_rice_carry_tracker.sv
// Directed bench for rice_carry_tracker at WORD_W=32: load, consume, span, stall,
// illegal lengths, flush and asynchronous reset.
module tb_rice_carry_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        word_valid;
   logic        word_ready;
   logic        len_valid;
   logic [5:0]  len;
   logic        len_ready;
   logic        flush;
   logic        cout;
   logic [5:0]  remlen;
   logic [4:0]  offset;
   logic [15:0] words;
   logic [1:0]  state;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   rice_carry_tracker dut (
      .clk        (clk),
      .reset      (reset),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .len_valid  (len_valid),
      .len        (len),
      .len_ready  (len_ready),
      .flush      (flush),
      .cout       (cout),
      .remlen     (remlen),
      .offset     (offset),
      .words      (words),
      .state      (state),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Consume one fitting length and return to no request.
   task automatic consume(input logic [5:0] l);
      len_valid = 1'b1;
      len       = l;
      step();
      len_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; word_valid = 1'b0; len_valid = 1'b0; len = '0; flush = 1'b0;
      #1;
      n_vec++; if ({state, remlen, offset, words, cout, err} !== '0) begin n_err++;
         $display("FAIL reset_regs: got %h want 0", {state, remlen, offset, words, cout, err}); end
      word_valid = 1'b1;
      #1;
      n_vec++; if (word_ready !== 1'b0) begin n_err++;
         $display("FAIL reset_word_ready: got %b want 0", word_ready); end
      word_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      n_vec++; if (state !== 2'd0) begin n_err++;
         $display("FAIL reset_state: got %0d want 0", state); end
   endtask

   task automatic test_load_consume();
      n_vec++; if (word_ready !== 1'b1 || len_ready !== 1'b0) begin n_err++;
         $display("FAIL idle_ready: got wr=%b lr=%b want wr=1 lr=0", word_ready, len_ready); end
      word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      n_vec++; if (remlen !== 6'd32 || state !== 2'd1 || words !== 16'd1) begin n_err++;
         $display("FAIL load: got rem=%0d st=%0d w=%0d want 32 1 1", remlen, state, words); end
      len_valid = 1'b1; len = 6'd3;
      #1;
      n_vec++; if (len_ready !== 1'b1 || word_ready !== 1'b0) begin n_err++;
         $display("FAIL consume_ready: got lr=%b wr=%b want 1 0", len_ready, word_ready); end
      step();
      len_valid = 1'b0;
      n_vec++; if (remlen !== 6'd29 || offset !== 5'd3 || cout !== 1'b0 || words !== 16'd1) begin
         n_err++; $display("FAIL consume3: got rem=%0d off=%0d c=%b w=%0d want 29 3 0 1",
                           remlen, offset, cout, words); end
      consume(6'd24);
      n_vec++; if (remlen !== 6'd5 || offset !== 5'd27) begin n_err++;
         $display("FAIL consume24: got rem=%0d off=%0d want 5 27", remlen, offset); end
   endtask

   task automatic test_span();
      len_valid = 1'b1; len = 6'd8; word_valid = 1'b1;
      #1;
      n_vec++; if (word_ready !== 1'b1 || len_ready !== 1'b1) begin n_err++;
         $display("FAIL span_ready: got wr=%b lr=%b want 1 1", word_ready, len_ready); end
      step();
      len_valid = 1'b0; word_valid = 1'b0;
      n_vec++; if (remlen !== 6'd29 || offset !== 5'd3 || cout !== 1'b1 || words !== 16'd2
                   || state !== 2'd1) begin n_err++;
         $display("FAIL span: got rem=%0d off=%0d c=%b w=%0d st=%0d want 29 3 1 2 1",
                  remlen, offset, cout, words, state); end
      step();
      n_vec++; if (cout !== 1'b0) begin n_err++;
         $display("FAIL span_pulse: got cout=%b want 0", cout); end
   endtask

   task automatic test_wait();
      consume(6'd24);
      len_valid = 1'b1; len = 6'd8; word_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_vec++; if (len_ready !== 1'b0 || word_ready !== 1'b0) begin n_err++;
            $display("FAIL wait_ready[%0d]: got lr=%b wr=%b want 0 0", i, len_ready, word_ready);
         end
         step();
         n_vec++; if (state !== 2'd2 || remlen !== 6'd5) begin n_err++;
            $display("FAIL wait_state[%0d]: got st=%0d rem=%0d want 2 5", i, state, remlen); end
      end
      word_valid = 1'b1;
      #1;
      n_vec++; if (len_ready !== 1'b1 || word_ready !== 1'b1) begin n_err++;
         $display("FAIL wait_release: got lr=%b wr=%b want 1 1", len_ready, word_ready); end
      step();
      word_valid = 1'b0; len_valid = 1'b0;
      n_vec++; if (remlen !== 6'd29 || cout !== 1'b1 || state !== 2'd1 || words !== 16'd3) begin
         n_err++; $display("FAIL wait_span: got rem=%0d c=%b st=%0d w=%0d want 29 1 1 3",
                           remlen, cout, state, words); end
   endtask

   task automatic test_illegal();
      len_valid = 1'b1; len = 6'd0;
      #1;
      n_vec++; if (len_ready !== 1'b1) begin n_err++;
         $display("FAIL len0_ready: got %b want 1", len_ready); end
      step();
      n_vec++; if (err !== 1'b1 || remlen !== 6'd29) begin n_err++;
         $display("FAIL len0: got err=%b rem=%0d want 1 29", err, remlen); end
      len = 6'd33;
      #1;
      n_vec++; if (len_ready !== 1'b1) begin n_err++;
         $display("FAIL len33_ready: got %b want 1", len_ready); end
      step();
      len_valid = 1'b0;
      n_vec++; if (err !== 1'b1 || remlen !== 6'd29 || state !== 2'd1) begin n_err++;
         $display("FAIL len33: got err=%b rem=%0d st=%0d want 1 29 1", err, remlen, state); end
      step();
      n_vec++; if (err !== 1'b1) begin n_err++;
         $display("FAIL err_sticky: got %b want 1", err); end
   endtask

   task automatic test_flush();
      consume(6'd12);
      n_vec++; if (remlen !== 6'd17) begin n_err++;
         $display("FAIL pre_flush: got rem=%0d want 17", remlen); end
      flush = 1'b1; len_valid = 1'b1; len = 6'd4;
      #1;
      n_vec++; if (len_ready !== 1'b0 || word_ready !== 1'b0) begin n_err++;
         $display("FAIL flush_ready: got lr=%b wr=%b want 0 0", len_ready, word_ready); end
      step();
      flush = 1'b0; len_valid = 1'b0;
      n_vec++; if (remlen !== 6'd0 || state !== 2'd0 || cout !== 1'b0 || offset !== 5'd0) begin
         n_err++; $display("FAIL flush: got rem=%0d st=%0d c=%b off=%0d want 0 0 0 0",
                           remlen, state, cout, offset); end
   endtask

   task automatic test_back_to_back();
      word_valid = 1'b1;
      step();
      word_valid = 1'b0;
      consume(6'd32);
      n_vec++; if (remlen !== 6'd0 || state !== 2'd0 || cout !== 1'b0 || words !== 16'd4) begin
         n_err++; $display("FAIL full_word: got rem=%0d st=%0d c=%b w=%0d want 0 0 0 4",
                           remlen, state, cout, words); end
      word_valid = 1'b1; len_valid = 1'b1; len = 6'd7;
      #1;
      n_vec++; if (len_ready !== 1'b0 || word_ready !== 1'b1) begin n_err++;
         $display("FAIL idle_len: got lr=%b wr=%b want 0 1", len_ready, word_ready); end
      step();
      word_valid = 1'b0;
      step();
      len_valid = 1'b0;
      n_vec++; if (remlen !== 6'd25 || offset !== 5'd7 || words !== 16'd5) begin n_err++;
         $display("FAIL reload: got rem=%0d off=%0d w=%0d want 25 7 5", remlen, offset, words);
      end
   endtask

   task automatic test_reset_mid();
      consume(6'd23);
      len_valid = 1'b1; len = 6'd8;
      step();
      n_vec++; if (state !== 2'd2 || remlen !== 6'd2) begin n_err++;
         $display("FAIL pre_reset_wait: got st=%0d rem=%0d want 2 2", state, remlen); end
      #2;
      reset = 1'b0;
      #1;
      n_vec++; if ({state, remlen, offset, words, cout, err, word_ready, len_ready} !== '0) begin
         n_err++; $display("FAIL async_reset: got %h want 0",
                           {state, remlen, offset, words, cout, err, word_ready, len_ready}); end
      len_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      n_vec++; if (state !== 2'd0 || word_ready !== 1'b1 || err !== 1'b0) begin n_err++;
         $display("FAIL post_reset: got st=%0d wr=%b err=%b want 0 1 0", state, word_ready, err);
      end
   endtask

   initial begin
      test_reset();
      test_load_consume();
      test_span();
      test_wait();
      test_illegal();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
